// File: rtl/fpt_motor_slew_stage.sv
`timescale 1ns/1ps
// Motor drive slew stage: merges command and correction into a saturated target and
// slews the drive toward it over valid/ready, with a veto ramp-to-zero and hold-off.
module fpt_motor_slew_stage #(
  parameter int unsigned W              = 16,
  parameter int unsigned DRIVE_MAX      = 30000,
  parameter int unsigned SLEW_BASE      = 64,
  parameter int unsigned HOLDOFF_CYCLES = 250
) (
  input  logic         clk_250mhz,
  input  logic         rst,
  input  logic [W-1:0] motor_command,
  input  logic [W-1:0] motor_correction,
  input  logic         corr_valid,
  input  logic         veto_in,
  input  logic [1:0]   attention_level,
  output logic [W-1:0] drive_out,
  output logic         drive_valid,
  input  logic         drive_ready,
  output logic [1:0]   state_out,
  output logic         veto_active,
  output logic         sat_flag
);

  localparam int unsigned SW         = W + 1;
  localparam int unsigned DW         = W + 2;
  localparam int unsigned CW         = $clog2(HOLDOFF_CYCLES + 1);
  localparam int unsigned RAMP_SHIFT = 3;

  localparam logic signed [SW-1:0] MAX_P     = SW'(DRIVE_MAX);
  localparam logic signed [SW-1:0] MAX_N     = -MAX_P;
  localparam logic [CW-1:0]        HOLD_LOAD = CW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    RAMP  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  target_q, target_d;
  logic [W-1:0]  drive_d;
  logic          valid_d;
  logic          sat_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic signed [SW-1:0] sum_c;
  logic [W-1:0]         clip_c;
  logic                 clip_sat_c;

  logic [1:0]           shamt_c;
  logic signed [DW-1:0] slew_c;
  logic signed [DW-1:0] cur_c;
  logic signed [DW-1:0] diff_c;
  logic signed [DW-1:0] mag_c;
  logic signed [DW-1:0] stepped_c;
  logic [W-1:0]         step_c;

  logic xfer_c;
  logic advance_c;
  logic veto_entry_c;

  // Saturated sum of command and correction, one bit wider than the operands.
  always_comb begin
    sum_c      = $signed({motor_command[W-1], motor_command}) +
                 $signed({motor_correction[W-1], motor_correction});
    clip_c     = W'(sum_c);
    clip_sat_c = 1'b0;
    if (sum_c > MAX_P) begin
      clip_c     = W'(MAX_P);
      clip_sat_c = 1'b1;
    end else if (sum_c < MAX_N) begin
      clip_c     = W'(MAX_N);
      clip_sat_c = 1'b1;
    end
  end

  // One slew step from the current drive toward the target.
  always_comb begin
    shamt_c   = (state_q == RAMP) ? 2'(RAMP_SHIFT) : attention_level;
    slew_c    = DW'(SLEW_BASE) << shamt_c;
    cur_c     = $signed({{2{drive_out[W-1]}}, drive_out});
    diff_c    = $signed({{2{target_q[W-1]}}, target_q}) - cur_c;
    mag_c     = diff_c[DW-1] ? -diff_c : diff_c;
    stepped_c = diff_c[DW-1] ? (cur_c - slew_c) : (cur_c + slew_c);
    step_c    = (mag_c <= slew_c) ? target_q : W'(stepped_c);
  end

  // Next-state, target, hold counter and output handshake.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    drive_d      = drive_out;
    valid_d      = drive_valid;
    sat_d        = sat_flag;
    cnt_d        = cnt_q;
    xfer_c       = drive_valid && drive_ready;
    advance_c    = !drive_valid || drive_ready;
    veto_entry_c = veto_in && ((state_q == IDLE) || (state_q == TRACK));

    unique case (state_q)
      IDLE, TRACK: begin
        if (veto_in) begin
          state_d  = RAMP;
          target_d = '0;
        end else if (corr_valid) begin
          state_d  = TRACK;
          target_d = clip_c;
          sat_d    = clip_sat_c;
        end
      end
      RAMP: begin
        if ((drive_out == '0) && (xfer_c || !drive_valid)) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (veto_in) begin
          cnt_d = HOLD_LOAD;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase

    // The veto cycle itself emits no step: the old target is already discarded.
    if (state_q == HOLD) begin
      drive_d = '0;
      valid_d = 1'b0;
    end else if (advance_c) begin
      if (!veto_entry_c && (drive_out != target_q)) begin
        drive_d = step_c;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_250mhz or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      target_q    <= '0;
      drive_out   <= '0;
      drive_valid <= 1'b0;
      sat_flag    <= 1'b0;
      cnt_q       <= '0;
      veto_active <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      drive_out   <= drive_d;
      drive_valid <= valid_d;
      sat_flag    <= sat_d;
      cnt_q       <= cnt_d;
      veto_active <= (state_d == RAMP) || (state_d == HOLD);
    end
  end

  assign state_out = 2'(state_q);

endmodule

// File: tb/tb_fpt_motor_slew_stage.sv
`timescale 1ns/1ps
// Bench for fpt_motor_slew_stage: table vectors, veto/hold/reset sequences and random
// samples, all checked against a transfer-level model of the slew sequence.
module tb_fpt_motor_slew_stage;

  localparam int W         = 16;
  localparam int DRIVE_MAX = 30000;
  localparam int SLEW_BASE = 64;
  localparam int BOUND     = 4000;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] motor_command;
  logic [W-1:0] motor_correction;
  logic         corr_valid;
  logic         veto_in;
  logic [1:0]   attention_level;
  logic [W-1:0] drive_out;
  logic         drive_valid;
  logic         drive_ready;
  logic [1:0]   state_out;
  logic         veto_active;
  logic         sat_flag;

  fpt_motor_slew_stage dut (
    .clk_250mhz       (clk),
    .rst              (rst),
    .motor_command    (motor_command),
    .motor_correction (motor_correction),
    .corr_valid       (corr_valid),
    .veto_in          (veto_in),
    .attention_level  (attention_level),
    .drive_out        (drive_out),
    .drive_valid      (drive_valid),
    .drive_ready      (drive_ready),
    .state_out        (state_out),
    .veto_active      (veto_active),
    .sat_flag         (sat_flag)
  );

  always #2 clk = ~clk;

  typedef struct {
    int cmd;
    int corr;
    int attn;
    int exp_target;
    int exp_sat;
    int exp_n;
  } vec_t;

  vec_t         vecs[10];
  int           tests = 0;
  int           failed = 0;
  int           model_cur;
  int           exp_q[$];
  int           obs_q[$];
  int           ready_mode;
  int           cyc;
  logic         prev_stall;
  logic [W-1:0] prev_out;

  function automatic int clip(input int s);
    if (s > DRIVE_MAX) return DRIVE_MAX;
    if (s < -DRIVE_MAX) return -DRIVE_MAX;
    return s;
  endfunction

  function automatic int sext(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  // Expected transfer list: approach tgt from cur in jumps of at most slew.
  task automatic build_expected(input int cur, input int tgt, input int slew);
    exp_q.delete();
    while (cur != tgt) begin
      if (tgt - cur > slew) cur = cur + slew;
      else if (cur - tgt > slew) cur = cur - slew;
      else cur = tgt;
      exp_q.push_back(cur);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock at the negedge: pick ready, log transfers, check held values.
  task automatic step_cycle();
    case (ready_mode)
      0:       drive_ready = ($urandom_range(0, 3) != 0);
      2:       drive_ready = !(cyc >= 3 && cyc < 13);
      default: drive_ready = 1'b1;
    endcase
    if (prev_stall) begin
      chk("stall_valid_held", int'(drive_valid), 1);
      chk("stall_value_held", sext(drive_out), sext(prev_out));
    end
    if (drive_valid && drive_ready) obs_q.push_back(sext(drive_out));
    prev_stall = drive_valid && !drive_ready;
    prev_out   = drive_out;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_sample(input int cmd, input int corr, input int attn,
                            input int exp_target, input int exp_sat,
                            input int exp_n, input int mode);
    int tgt;
    int n;
    tgt = clip(cmd + corr);
    build_expected(model_cur, tgt, SLEW_BASE << attn);
    obs_q.delete();
    cyc              = 0;
    ready_mode       = mode;
    motor_command    = W'(cmd);
    motor_correction = W'(corr);
    attention_level  = 2'(attn);
    corr_valid       = 1'b1;
    step_cycle();
    corr_valid = 1'b0;
    step_cycle();
    if (exp_q.size() > 0) chk("latency_valid", int'(drive_valid), 1);
    n = 0;
    while (drive_valid && n < BOUND) begin
      step_cycle();
      n++;
    end
    chk("slew_timeout", int'(n < BOUND), 1);
    if (exp_n >= 0) chk("transfer_count", obs_q.size(), exp_n);
    chk("model_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size(); i++)
      chk("step_value", obs_q[i], (i < exp_q.size()) ? exp_q[i] : 99999);
    chk("final_drive", sext(drive_out), exp_target);
    chk("sat_flag", int'(sat_flag), exp_sat);
    chk("state_track", int'(state_out), 1);
    model_cur = tgt;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int hold_n;
    int hold_bad;
    int cmd;
    int corr;
    int attn;
    int tgt;
    logic [W-1:0] rc;

    vecs[0] = '{1000,    200,    0, 1200,   0, 19};
    vecs[1] = '{30000,   5000,   3, 30000,  1, 57};
    vecs[2] = '{-32768,  -32768, 3, -30000, 1, 118};
    vecs[3] = '{100,     0,      3, 100,    0, 59};
    vecs[4] = '{-50,     20,     1, -30,    0, 2};
    vecs[5] = '{-30,     0,      2, -30,    0, 0};
    vecs[6] = '{32767,   -2767,  2, 30000,  0, 118};
    vecs[7] = '{30001,   0,      0, 30000,  1, 0};
    vecs[8] = '{-30000,  0,      3, -30000, 0, 118};
    vecs[9] = '{0,       0,      0, 0,      0, 469};

    rst              = 1'b0;
    motor_command    = '0;
    motor_correction = '0;
    corr_valid       = 1'b0;
    veto_in          = 1'b0;
    attention_level  = 2'd0;
    drive_ready      = 1'b1;
    prev_stall       = 1'b0;
    prev_out         = '0;
    ready_mode       = 1;
    cyc              = 0;
    model_cur        = 0;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_drive", sext(drive_out), 0);
    chk("reset_valid", int'(drive_valid), 0);
    chk("reset_state", int'(state_out), 0);
    chk("reset_veto_active", int'(veto_active), 0);
    chk("reset_sat", int'(sat_flag), 0);
    rst = 1'b0;
    step_cycle();
    chk("idle_after_reset", int'(drive_valid), 0);

    // Table vectors with random backpressure.
    for (int v = 0; v < 10; v++)
      run_sample(vecs[v].cmd, vecs[v].corr, vecs[v].attn,
                 vecs[v].exp_target, vecs[v].exp_sat, vecs[v].exp_n, 0);

    // Ten-cycle stall mid-slew at the fastest tracking rate.
    run_sample(5000, 0, 3, 5000, 0, 10, 2);

    // Veto from a settled drive of 1000.
    run_sample(1000, 0, 0, 1000, 0, 63, 1);
    obs_q.delete();
    veto_in = 1'b1;
    step_cycle();
    veto_in = 1'b0;
    chk("veto_state_ramp", int'(state_out), 2);
    chk("veto_active_ramp", int'(veto_active), 1);
    n = 0;
    while (state_out == 2'd2 && n < 50) begin
      step_cycle();
      n++;
    end
    chk("ramp_count", obs_q.size(), 2);
    chk("ramp_step0", (obs_q.size() > 0) ? obs_q[0] : 99999, 488);
    chk("ramp_step1", (obs_q.size() > 1) ? obs_q[1] : 99999, 0);
    chk("hold_entry", int'(state_out), 3);
    chk("veto_active_hold", int'(veto_active), 1);
    hold_n   = 0;
    hold_bad = 0;
    while (state_out == 2'd3 && hold_n < 1000) begin
      if (drive_valid || drive_out != '0) hold_bad++;
      if (hold_n == 10) begin
        motor_command    = 16'h7fff;
        motor_correction = 16'h7fff;
        corr_valid       = 1'b1;
      end
      step_cycle();
      corr_valid = 1'b0;
      hold_n++;
    end
    chk("hold_length", hold_n, 250);
    chk("hold_outputs", hold_bad, 0);
    chk("after_hold_state", int'(state_out), 0);
    chk("after_hold_veto_active", int'(veto_active), 0);
    chk("hold_sample_ignored_sat", int'(sat_flag), 0);
    step_cycle();
    step_cycle();
    chk("hold_sample_ignored_valid", int'(drive_valid), 0);
    model_cur = 0;

    // Sample and veto together from TRACK; veto again in HOLD at count 100.
    run_sample(300, 0, 0, 300, 0, 5, 1);
    obs_q.delete();
    motor_command    = 16'h7fff;
    motor_correction = 16'h7fff;
    corr_valid       = 1'b1;
    veto_in          = 1'b1;
    step_cycle();
    corr_valid = 1'b0;
    veto_in    = 1'b0;
    chk("simul_state_ramp", int'(state_out), 2);
    chk("simul_sat_kept", int'(sat_flag), 0);
    n = 0;
    while (state_out == 2'd2 && n < 50) begin
      step_cycle();
      n++;
    end
    chk("simul_ramp_count", obs_q.size(), 1);
    chk("simul_ramp_step0", (obs_q.size() > 0) ? obs_q[0] : 99999, 0);
    hold_n = 0;
    while (state_out == 2'd3 && hold_n < 1000) begin
      if (hold_n == 149) veto_in = 1'b1;
      step_cycle();
      veto_in = 1'b0;
      hold_n++;
    end
    chk("hold_reload_length", hold_n, 400);
    chk("reload_exit_state", int'(state_out), 0);
    model_cur = 0;

    // Random samples against the model.
    for (int r = 0; r < 20; r++) begin
      rc   = W'($urandom);
      cmd  = sext(rc);
      corr = int'($urandom_range(0, 8000)) - 4000;
      attn = int'($urandom_range(0, 3));
      tgt  = clip(cmd + corr);
      run_sample(cmd, corr, attn, tgt, int'(tgt != cmd + corr), -1, 0);
    end

    // Asynchronous reset with a value in flight.
    run_sample(500, 0, 3, 500, 0, -1, 1);
    build_expected(500, 30000, SLEW_BASE);
    ready_mode       = 1;
    motor_command    = W'(30000);
    motor_correction = W'(5000);
    attention_level  = 2'd0;
    corr_valid       = 1'b1;
    step_cycle();
    corr_valid = 1'b0;
    step_cycle();
    chk("inflight_valid", int'(drive_valid), 1);
    chk("inflight_value", sext(drive_out), exp_q[0]);
    chk("inflight_sat", int'(sat_flag), 1);
    #1 rst = 1'b1;
    #0.5;
    chk("async_reset_drive", sext(drive_out), 0);
    chk("async_reset_valid", int'(drive_valid), 0);
    chk("async_reset_state", int'(state_out), 0);
    chk("async_reset_sat", int'(sat_flag), 0);
    chk("async_reset_veto_active", int'(veto_active), 0);
    @(negedge clk);
    rst        = 1'b0;
    prev_stall = 1'b0;
    model_cur  = 0;
    repeat (3) step_cycle();
    chk("post_reset_quiet", int'(drive_valid), 0);
    chk("post_reset_state", int'(state_out), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
